// File: rtl/icache_assoc_pkg.sv
// Shared types for the I-side L1: the fetch word and the fill controller states.
package icache_assoc_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    // Index width that stays at least one bit so degenerate sizes still give legal vectors.
    function automatic int unsigned min1_clog2(input int unsigned n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/icache_assoc_plru.sv
// Per-set tree pseudo-LRU: one bit per internal node, 0 steers the victim walk to the lower half.
module icache_plru
    import icache_assoc_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int SETS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_clr,
    input  logic                       i_touch,
    input  logic [$clog2(SETS)-1:0]    i_touch_set,
    input  logic [min1_clog2(WAYS)-1:0] i_touch_way,
    input  logic [$clog2(SETS)-1:0]    i_vic_set,
    output logic [min1_clog2(WAYS)-1:0] o_victim
);

    localparam int WAY_W = min1_clog2(WAYS);
    localparam int LVL   = $clog2(WAYS);

    generate
        if (WAYS == 1) begin : g_dm
            assign o_victim = '0;
        end else begin : g_tree
            logic [WAYS-2:0]  r_tree [SETS];
            logic [WAYS-2:0]  w_upd;
            logic [WAY_W-1:0] w_vn;
            logic [WAY_W-1:0] w_vic;
            logic [WAY_W-1:0] w_tn;
            logic             w_b;

            // Walk the tree from the root following the stored bits to the victim leaf.
            always_comb begin
                w_vn  = '0;
                w_vic = '0;
                for (int l = 0; l < LVL; l++) begin
                    w_vic = WAY_W'({w_vic, r_tree[i_vic_set][w_vn]});
                    w_vn  = WAY_W'(2 * int'(w_vn) + 1 + int'(r_tree[i_vic_set][w_vn]));
                end
            end

            assign o_victim = w_vic;

            // Point every node on the touched way's path away from it.
            always_comb begin
                w_upd = r_tree[i_touch_set];
                w_tn  = '0;
                w_b   = 1'b0;
                for (int l = 0; l < LVL; l++) begin
                    w_b        = |(i_touch_way & (WAY_W'(1) << (LVL - 1 - l)));
                    w_upd[w_tn] = ~w_b;
                    w_tn       = WAY_W'(2 * int'(w_tn) + 1 + int'(w_b));
                end
            end

            // Tree state: cleared by reset and flush, updated on touch.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < SETS; s++) r_tree[s] <= '0;
                end else if (i_clr) begin
                    for (int s = 0; s < SETS; s++) r_tree[s] <= '0;
                end else if (i_touch) begin
                    r_tree[i_touch_set] <= w_upd;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache with multi-word blocks, PLRU replacement,
// a single outstanding block fill and a one-cycle whole-cache flush.
module icache_assoc
    import icache_assoc_pkg::*;
#(
    parameter int WAYS     = 2,
    parameter int SETS     = 8,
    parameter int BLK_WRDS = 2,
    parameter int ADDR_W   = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              imemREN,
    input  logic [ADDR_W-1:0] imemaddr,
    input  logic              iflush,
    output logic              ihit,
    output word_t             imemload,
    output logic              iREN,
    output logic [ADDR_W-1:0] iaddr,
    input  logic              iwait,
    input  word_t             iload
);

    localparam int OFF_W = $clog2(BLK_WRDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
    localparam int CNT_W = min1_clog2(BLK_WRDS);
    localparam int WAY_W = min1_clog2(WAYS);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [CNT_W-1:0] off;
    } addr_split_t;

    // Shifts rather than slices so a one-word block (OFF_W=0) needs no special case.
    function automatic addr_split_t split_addr(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] w;
        addr_split_t       s;
        w     = a >> 2;
        s.off = CNT_W'(w & ADDR_W'(BLK_WRDS - 1));
        s.idx = IDX_W'(w >> OFF_W);
        s.tag = TAG_W'(w >> (OFF_W + IDX_W));
        return s;
    endfunction

    icache_state_t    r_state, w_next;
    logic             r_valid [SETS][WAYS];
    logic [TAG_W-1:0] r_tags  [SETS][WAYS];
    word_t            r_data  [SETS][WAYS][BLK_WRDS];
    logic [TAG_W-1:0] r_tag;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [WAY_W-1:0] r_vic;

    addr_split_t      w_req;
    logic             w_hit_any, w_inv_any, w_miss, w_accept, w_fill_done, w_touch;
    logic [WAY_W-1:0] w_hit_way, w_inv_way, w_plru_vic, w_victim;
    logic [ADDR_W-1:0] w_fill_addr;

    assign w_req = split_addr(imemaddr);

    // Tag compare across the indexed set; descending scan leaves the lowest invalid way.
    always_comb begin
        w_hit_any = 1'b0;
        w_hit_way = '0;
        w_inv_any = 1'b0;
        w_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            w_hit_any = w_hit_any | (r_valid[w_req.idx][w] & (r_tags[w_req.idx][w] == w_req.tag));
            w_hit_way = (r_valid[w_req.idx][w] & (r_tags[w_req.idx][w] == w_req.tag)) ? WAY_W'(w) : w_hit_way;
            w_inv_any = w_inv_any | ~r_valid[w_req.idx][w];
            w_inv_way = ~r_valid[w_req.idx][w] ? WAY_W'(w) : w_inv_way;
        end
    end

    assign w_victim    = w_inv_any ? w_inv_way : w_plru_vic;
    assign w_fill_addr = (ADDR_W'(r_tag) << (OFF_W + IDX_W + 2)) |
                         (ADDR_W'(r_idx) << (OFF_W + 2)) |
                         (ADDR_W'(r_cnt) << 2);

    // Next-state and fetch/memory handshake outputs.
    always_comb begin
        w_next      = r_state;
        ihit        = 1'b0;
        iREN        = 1'b0;
        iaddr       = '0;
        w_miss      = 1'b0;
        w_fill_done = 1'b0;
        case (r_state)
            IDLE: begin
                ihit   = imemREN & ~iflush & w_hit_any;
                w_miss = imemREN & ~iflush & ~w_hit_any;
                w_next = w_miss ? FILL : IDLE;
            end
            FILL: begin
                iREN        = 1'b1;
                iaddr       = w_fill_addr;
                w_fill_done = ~iwait & (r_cnt == CNT_W'(BLK_WRDS - 1));
                if (iflush) begin
                    w_next = IDLE;
                end else if (w_fill_done) begin
                    w_next = IDLE;
                end else begin
                    w_next = FILL;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_accept = iREN & ~iwait;
    assign imemload = ihit ? r_data[w_req.idx][w_hit_way][w_req.off] : '0;
    assign w_touch  = ihit | (w_fill_done & ~iflush);

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Fill bookkeeping and valid bits; flush wins over any same-cycle fill completion.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) r_valid[s][w] <= 1'b0;
            r_tag <= '0;
            r_idx <= '0;
            r_cnt <= '0;
            r_vic <= '0;
        end else begin
            if (w_miss) begin
                r_tag <= w_req.tag;
                r_idx <= w_req.idx;
                r_vic <= w_victim;
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (iflush) begin
                for (int s = 0; s < SETS; s++)
                    for (int w = 0; w < WAYS; w++) r_valid[s][w] <= 1'b0;
            end else if (w_miss) begin
                r_valid[w_req.idx][w_victim] <= 1'b0;
            end else if (w_fill_done) begin
                r_valid[r_idx][r_vic] <= 1'b1;
            end
        end
    end

    // Tag and data storage; contents are meaningless until the matching valid bit is set.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_data[r_idx][r_vic][r_cnt] <= iload;
        end
        if (w_fill_done) begin
            r_tags[r_idx][r_vic] <= r_tag;
        end
    end

    icache_plru #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_plru (
        .clk         (CLK),
        .rst         (RST),
        .i_clr       (iflush),
        .i_touch     (w_touch),
        .i_touch_set (ihit ? w_req.idx : r_idx),
        .i_touch_way (ihit ? w_hit_way : r_vic),
        .i_vic_set   (w_req.idx),
        .o_victim    (w_plru_vic)
    );

endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench for icache_assoc: directed scenarios plus randomized fetches checked
// against an LRU cache model (equivalent to tree-PLRU for two ways) and a hashed memory image.
module tb_icache_assoc;

    localparam int WAYS = 2;
    localparam int SETS = 8;
    localparam int BLK  = 2;
    localparam int AW   = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic          imemREN;
    logic [AW-1:0] imemaddr;
    logic          iflush;
    logic          ihit;
    logic [31:0]   imemload;
    logic          iREN;
    logic [AW-1:0] iaddr;
    logic          iwait;
    logic [31:0]   iload;

    int checks = 0;
    int errors = 0;

    bit          m_valid [SETS][WAYS];
    int unsigned m_tag   [SETS][WAYS];
    int          m_stamp [SETS][WAYS];
    int          now_t = 0;

    always #5 CLK = ~CLK;

    icache_assoc #(.WAYS(WAYS), .SETS(SETS), .BLK_WRDS(BLK), .ADDR_W(AW)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .iflush(iflush),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    function automatic int m_set(input logic [31:0] a);
        return int'(((a >> 2) / BLK) % SETS);
    endfunction

    function automatic int unsigned m_tagof(input logic [31:0] a);
        return (a >> 2) / (BLK * SETS);
    endfunction

    function automatic int m_lookup(input logic [31:0] a);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[m_set(a)][w] && m_tag[m_set(a)][w] == m_tagof(a)) return w;
        return -1;
    endfunction

    function automatic int m_victim(input int s);
        int v;
        for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
        v = 0;
        for (int w = 1; w < WAYS; w++) if (m_stamp[s][w] < m_stamp[s][v]) v = w;
        return v;
    endfunction

    task automatic m_clear;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_stamp[s][w] = 0;
            end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // One fetch of address a; on a miss every fill cycle is checked. With has_alt the
    // fetch address switches to alt after the miss and the post-fill hit check is skipped.
    task automatic fetch(input logic [31:0] a, input int wt, input bit has_alt,
                         input logic [31:0] alt, input string nm);
        int w, v, s;
        logic [31:0] base, ea;
        imemREN = 1'b1; imemaddr = a; iflush = 1'b0; iwait = 1'b0; iload = 32'h0;
        @(negedge CLK);
        w = m_lookup(a);
        s = m_set(a);
        checks++;
        if (w >= 0) begin
            if (ihit !== 1'b1 || imemload !== mem_word(a & ~32'h3) || iREN !== 1'b0) begin
                errors++;
                $display("FAIL %s_hit addr=%h: ihit=%b imemload=%h iREN=%b, expected ihit=1 imemload=%h iREN=0",
                         nm, a, ihit, imemload, iREN, mem_word(a & ~32'h3));
            end
            now_t++;
            m_stamp[s][w] = now_t;
            step;
            return;
        end
        if (ihit !== 1'b0 || iREN !== 1'b0) begin
            errors++;
            $display("FAIL %s_miss addr=%h: ihit=%b iREN=%b, expected 0 0", nm, a, ihit, iREN);
        end
        v = m_victim(s);
        m_valid[s][v] = 1'b0;
        base = a & ~32'(BLK * 4 - 1);
        step;
        if (has_alt) imemaddr = alt;
        for (int k = 0; k < BLK; k++) begin
            for (int c = 0; c <= wt; c++) begin
                iwait = (c < wt);
                ea    = base + 32'(k * 4);
                iload = iwait ? 32'hDEAD_BEEF : mem_word(ea);
                @(negedge CLK);
                checks++;
                if (iREN !== 1'b1 || iaddr !== ea || ihit !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_fill word=%0d: iREN=%b iaddr=%h ihit=%b, expected iREN=1 iaddr=%h ihit=0",
                             nm, k, iREN, iaddr, ihit, ea);
                end
                step;
            end
        end
        iwait = 1'b0; iload = 32'h0;
        now_t++;
        m_valid[s][v] = 1'b1;
        m_tag[s][v]   = m_tagof(a);
        m_stamp[s][v] = now_t;
        if (!has_alt) begin
            @(negedge CLK);
            checks++;
            if (ihit !== 1'b1 || imemload !== mem_word(a & ~32'h3) || iREN !== 1'b0) begin
                errors++;
                $display("FAIL %s_after_fill addr=%h: ihit=%b imemload=%h iREN=%b, expected ihit=1 imemload=%h iREN=0",
                         nm, a, ihit, imemload, iREN, mem_word(a & ~32'h3));
            end
            now_t++;
            m_stamp[s][v] = now_t;
            step;
        end
    endtask

    task automatic test_reset;
        RST = 1'b1; imemREN = 1'b1; imemaddr = 32'h100; iflush = 1'b0; iwait = 1'b0; iload = 32'h0;
        m_clear();
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (ihit !== 1'b0 || iREN !== 1'b0 || iaddr !== 32'h0 || imemload !== 32'h0) begin
            errors++;
            $display("FAIL reset: ihit=%b iREN=%b iaddr=%h imemload=%h, expected all 0", ihit, iREN, iaddr, imemload);
        end
        RST = 1'b0; imemREN = 1'b0;
        step;
    endtask

    task automatic test_fill_hit;
        fetch(32'h100, 0, 1'b0, 32'h0, "t1_fill");
        fetch(32'h104, 0, 1'b0, 32'h0, "t2_same_block");
    endtask

    task automatic test_evict;
        fetch(32'h000, 0, 1'b0, 32'h0, "t3_a");
        fetch(32'h040, 0, 1'b0, 32'h0, "t3_b");
        fetch(32'h080, 0, 1'b0, 32'h0, "t3_c");
        fetch(32'h040, 0, 1'b0, 32'h0, "t3_b_kept");
        fetch(32'h000, 0, 1'b0, 32'h0, "t3_a_evicted");
    endtask

    task automatic test_wait;
        fetch(32'h200, 3, 1'b0, 32'h0, "t4_wait");
        fetch(32'h204, 0, 1'b0, 32'h0, "t4_second");
    endtask

    task automatic test_flush;
        fetch(32'h100, 0, 1'b0, 32'h0, "t5_prefill");
        // Flush while idle on a cached address: no hit, no miss started.
        imemREN = 1'b1; imemaddr = 32'h100; iflush = 1'b1;
        @(negedge CLK);
        checks++;
        if (ihit !== 1'b0 || iREN !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: ihit=%b iREN=%b, expected 0 0", ihit, iREN);
        end
        step;
        iflush = 1'b0; imemREN = 1'b0;
        m_clear();
        @(negedge CLK);
        checks++;
        if (iREN !== 1'b0 || ihit !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_after: iREN=%b ihit=%b, expected 0 0", iREN, ihit);
        end
        step;
        fetch(32'h100, 0, 1'b0, 32'h0, "t5_refill");
        // Flush on the second fill word of 0x300.
        imemREN = 1'b1; imemaddr = 32'h300;
        @(negedge CLK);
        checks++;
        if (ihit !== 1'b0 || iREN !== 1'b0) begin
            errors++;
            $display("FAIL flush_fill_miss: ihit=%b iREN=%b, expected 0 0", ihit, iREN);
        end
        step;
        iload = mem_word(32'h300);
        @(negedge CLK);
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h300) begin
            errors++;
            $display("FAIL flush_fill_w0: iREN=%b iaddr=%h, expected 1 00000300", iREN, iaddr);
        end
        step;
        iflush = 1'b1; iload = mem_word(32'h304);
        @(negedge CLK);
        checks++;
        if (iREN !== 1'b1 || iaddr !== 32'h304 || ihit !== 1'b0) begin
            errors++;
            $display("FAIL flush_fill_w1: iREN=%b iaddr=%h ihit=%b, expected 1 00000304 0", iREN, iaddr, ihit);
        end
        step;
        iflush = 1'b0; imemREN = 1'b0; iload = 32'h0;
        m_clear();
        @(negedge CLK);
        checks++;
        if (iREN !== 1'b0 || ihit !== 1'b0) begin
            errors++;
            $display("FAIL flush_abort: iREN=%b ihit=%b, expected 0 0", iREN, ihit);
        end
        step;
        fetch(32'h300, 0, 1'b0, 32'h0, "t5_300_miss");
        fetch(32'h100, 0, 1'b0, 32'h0, "t5_100_miss");
    endtask

    task automatic test_branch;
        fetch(32'h400, 0, 1'b1, 32'h500, "t6_400");
        fetch(32'h500, 0, 1'b0, 32'h0,   "t6_500");
        fetch(32'h404, 0, 1'b0, 32'h0,   "t6_404");
    endtask

    task automatic test_rst_mid_fill;
        imemREN = 1'b1; imemaddr = 32'h600; iflush = 1'b0; iwait = 1'b1;
        @(negedge CLK);
        checks++;
        if (ihit !== 1'b0) begin
            errors++;
            $display("FAIL rst_fill_miss: ihit=%b, expected 0", ihit);
        end
        step;
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (iREN !== 1'b0 || iaddr !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_fill: iREN=%b iaddr=%h, expected 0 00000000", iREN, iaddr);
        end
        m_clear();
        step;
        RST = 1'b0; iwait = 1'b0;
        fetch(32'h100, 0, 1'b0, 32'h0, "rst_refill");
    endtask

    task automatic test_random;
        logic [31:0] a, alt;
        int r;
        for (int i = 0; i < 80; i++) begin
            a   = 32'(((int'($urandom_range(0, 3)) * SETS * BLK) +
                       (($urandom_range(0, 1) == 0 ? 0 : 3) * BLK) + int'($urandom_range(0, BLK - 1))) * 4);
            alt = 32'(($urandom_range(0, 31) * 4));
            r   = int'($urandom_range(0, 9));
            if (r == 0) begin
                imemREN = 1'b0; iflush = 1'b0;
                @(negedge CLK);
                checks++;
                if (ihit !== 1'b0 || iREN !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_idle: ihit=%b iREN=%b, expected 0 0", ihit, iREN);
                end
                step;
            end else if (r == 1) begin
                imemREN = 1'b1; imemaddr = a; iflush = 1'b1;
                @(negedge CLK);
                checks++;
                if (ihit !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_flush: ihit=%b, expected 0", ihit);
                end
                step;
                iflush = 1'b0;
                m_clear();
            end else if (r == 2) begin
                fetch(a, int'($urandom_range(0, 2)), 1'b1, alt, "rand_branch");
            end else begin
                fetch(a, int'($urandom_range(0, 2)), 1'b0, 32'h0, "rand");
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_hit();
        test_evict();
        test_wait();
        test_flush();
        test_branch();
        test_rst_mid_fill();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
